// File: rtl/xlr8_text_ram_ctrl.sv
// ----------------------------------------------------------------------------
// xlr8_text_ram_ctrl
// Port-A controller for the HDMI text-mode char and attr RAMs (COLS x ROWS
// cells). The AVR host always wins port A. A fill/scroll engine uses the
// cycles the host leaves idle.
//
// Ports
//   clk_core, rst, clken      : core clock, sync active-high reset, clock enable
//   host_req/we/sel/addr/wdata: host byte access (sel 0=char, 1=attr)
//   host_rdata, host_rvalid   : registered read data and its 1-cycle strobe
//   cmd_start/op/char/attr    : engine command (op 00=FILL, 01=SCROLL_UP)
//   busy, done                : engine running / 1-cycle completion pulse
//   ram_*                     : shared port A of the char and attr RAMs
// ----------------------------------------------------------------------------
module xlr8_text_ram_ctrl #(
    parameter int ADDR_W = 13,
    parameter int COLS   = 80,
    parameter int ROWS   = 30
) (
    input  logic              clk_core,
    input  logic              rst,
    input  logic              clken,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_sel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    input  logic              cmd_start,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_char,
    input  logic [7:0]        cmd_attr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_char_wdata,
    output logic [7:0]        ram_attr_wdata,
    output logic              ram_char_we,
    output logic              ram_attr_we,
    output logic              ram_re,
    input  logic [7:0]        ram_char_q,
    input  logic [7:0]        ram_attr_q
);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_SRC  = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, FILL, SC_RD, SC_WR, SC_CLR, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        fill_char_q, fill_char_d;
    logic [7:0]        fill_attr_q, fill_attr_d;
    logic              hold_valid_q, hold_valid_d;
    logic [7:0]        hold_char_q, hold_char_d;
    logic [7:0]        hold_attr_q, hold_attr_d;
    logic              rd_pend_q;
    logic              rd_sel_q;
    logic [7:0]        host_rdata_q;
    logic              host_rvalid_q;

    logic              eng_active;
    logic              eng_we;
    logic              eng_re;
    logic [ADDR_W-1:0] eng_addr;
    logic [7:0]        eng_char;
    logic [7:0]        eng_attr;
    logic              host_grant;
    logic              eng_go;

    // Engine's view of port A, before arbitration.
    always_comb begin
        eng_active = (state_q == FILL) || (state_q == SC_RD) ||
                     (state_q == SC_WR) || (state_q == SC_CLR);
        eng_we   = 1'b0;
        eng_re   = 1'b0;
        eng_addr = cnt_q;
        eng_char = fill_char_q;
        eng_attr = fill_attr_q;
        case (state_q)
            FILL, SC_CLR: eng_we = 1'b1;
            SC_RD: begin
                eng_re   = 1'b1;
                eng_addr = cnt_q + ROW_STEP;
            end
            SC_WR: begin
                // q may have been overwritten by a host read after a stall,
                // so a captured copy takes precedence.
                eng_we   = 1'b1;
                eng_char = hold_valid_q ? hold_char_q : ram_char_q;
                eng_attr = hold_valid_q ? hold_attr_q : ram_attr_q;
            end
            default: ;
        endcase
    end

    // Next-state logic. A host request stalls any port-using engine state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_char_d  = fill_char_q;
        fill_attr_d  = fill_attr_q;
        hold_valid_d = hold_valid_q;
        hold_char_d  = hold_char_q;
        hold_attr_d  = hold_attr_q;
        if (clken) begin
            if (host_req && eng_active) begin
                // Capture the row-below data only once: a second stall would
                // see q already replaced by a host read.
                if (state_q == SC_WR && !hold_valid_q) begin
                    hold_valid_d = 1'b1;
                    hold_char_d  = ram_char_q;
                    hold_attr_d  = ram_attr_q;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_start) begin
                            cnt_d        = '0;
                            fill_char_d  = cmd_char;
                            fill_attr_d  = cmd_attr;
                            hold_valid_d = 1'b0;
                            case (cmd_op)
                                2'b00:   state_d = FILL;
                                2'b01:   state_d = SC_RD;
                                default: state_d = DONE;
                            endcase
                        end
                    end
                    FILL, SC_CLR: begin
                        if (cnt_q == LAST_CELL) state_d = DONE;
                        else                    cnt_d   = cnt_q + ONE;
                    end
                    SC_RD: state_d = SC_WR;
                    SC_WR: begin
                        // The copy phase ends exactly where the clear phase
                        // starts, so the counter always advances.
                        hold_valid_d = 1'b0;
                        cnt_d        = cnt_q + ONE;
                        state_d      = (cnt_q == LAST_SRC) ? SC_CLR : SC_RD;
                    end
                    DONE:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Port-A arbitration; rst suppresses all accesses in the cycle it is seen.
    always_comb begin
        host_grant     = host_req && clken && !rst;
        eng_go         = eng_active && clken && !host_req && !rst;
        ram_addr       = host_grant ? host_addr  : eng_addr;
        ram_char_wdata = host_grant ? host_wdata : eng_char;
        ram_attr_wdata = host_grant ? host_wdata : eng_attr;
        ram_char_we    = host_grant ? (host_we && !host_sel) : (eng_go && eng_we);
        ram_attr_we    = host_grant ? (host_we && host_sel)  : (eng_go && eng_we);
        ram_re         = host_grant ? !host_we : (eng_go && eng_re);
        busy           = eng_active;
        done           = (state_q == DONE) && clken;
        host_rvalid    = host_rvalid_q && clken;
        host_rdata     = host_rdata_q;
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            fill_char_q   <= '0;
            fill_attr_q   <= '0;
            hold_valid_q  <= 1'b0;
            hold_char_q   <= '0;
            hold_attr_q   <= '0;
            rd_pend_q     <= 1'b0;
            rd_sel_q      <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_char_q  <= fill_char_d;
            fill_attr_q  <= fill_attr_d;
            hold_valid_q <= hold_valid_d;
            hold_char_q  <= hold_char_d;
            hold_attr_q  <= hold_attr_d;
            // Host read pipeline: RAM q is valid in the cycle after the
            // request and is registered on the following enabled edge.
            if (clken) begin
                rd_pend_q     <= host_grant && !host_we;
                rd_sel_q      <= host_sel;
                host_rvalid_q <= rd_pend_q;
                if (rd_pend_q) begin
                    host_rdata_q <= rd_sel_q ? ram_attr_q : ram_char_q;
                end
            end
        end
    end
endmodule
